// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, baud rounding helper and ASCII constants
// used by the transmitter, the receiver and the game blocks.
package uart_pkg;

  localparam int unsigned DATA_W = 8;

  localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
  localparam logic [1:0] ST_START_ENC = 2'd1;
  localparam logic [1:0] ST_DATA_ENC  = 2'd2;
  localparam logic [1:0] ST_STOP_ENC  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE_ENC,
    START = ST_START_ENC,
    DATA  = ST_DATA_ENC,
    STOP  = ST_STOP_ENC
  } tx_state_e;

  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;

  // Nearest-integer clock cycles per bit
  function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                               input int unsigned baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_tx_buffered_if.sv
// Byte strobe / serial line bundle between the game blocks and the UART transmitter.
interface uart_tx_buffered_if;
  import uart_pkg::*;

  logic              i_transmit;
  logic [DATA_W-1:0] i_data;
  logic              o_tx;
  logic              o_busy;
  logic              o_ready;
  logic              o_done;
  logic              o_overrun;

  modport master (
    output i_transmit, i_data,
    input  o_tx, o_busy, o_ready, o_done, o_overrun
  );

  modport slave (
    input  i_transmit, i_data,
    output o_tx, o_busy, o_ready, o_done, o_overrun
  );
endinterface

// File: rtl/uart_baud_tick.sv
// Restartable bit-period counter: o_tick is high on the last cycle of each period,
// o_pre_tick_c flags that the next cycle will be that last cycle.
module uart_baud_tick #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  output logic o_tick,
  output logic o_pre_tick_c
);
  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);

  logic [CNT_W-1:0] cnt;

  assign o_pre_tick_c = !i_clear && (cnt == CNT_PRE);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt    <= '0;
      o_tick <= 1'b0;
    end else begin
      o_tick <= o_pre_tick_c;
      if (i_clear || (cnt == CNT_LAST)) cnt <= '0;
      else                              cnt <= cnt + CNT_W'(1);
    end
  end
endmodule

// File: rtl/uart_tx_buffered.sv
// 8N1 LSB-first UART transmitter with a one-byte holding register so a strobe
// arriving mid-frame is queued and sent back-to-back after the current stop bit.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned BAUD     = 9600
) (
  input  logic               i_clk,
  input  logic               i_rst,
  uart_tx_buffered_if.slave  bus
);
  localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);

  if (CLKS_PER_BIT < 2) begin : g_cpb_check
    $error("uart_tx_buffered: CLKS_PER_BIT must be at least 2");
  end

  tx_state_e         state, state_n;
  logic [DATA_W-1:0] shifter, shifter_n;
  logic [DATA_W-1:0] hold_data, hold_data_n;
  logic              hold_valid, hold_valid_n;
  logic [2:0]        bit_idx, bit_idx_n;
  logic              tx_n;
  logic              overrun_n;
  logic              clear_c;
  logic              tick;
  logic              pre_tick_c;
  logic              stop_end_c;

  uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_clear     (clear_c),
    .o_tick      (tick),
    .o_pre_tick_c(pre_tick_c)
  );

  assign stop_end_c = (state == STOP) && tick;

  // Next-state, shifter, holding register and line value
  always_comb begin
    state_n      = state;
    shifter_n    = shifter;
    hold_data_n  = hold_data;
    hold_valid_n = hold_valid;
    bit_idx_n    = bit_idx;
    tx_n         = bus.o_tx;
    overrun_n    = 1'b0;
    clear_c      = 1'b0;

    case (state)
      IDLE: begin
        if (bus.i_transmit) begin
          shifter_n = bus.i_data;
          state_n   = START;
          tx_n      = 1'b0;
          clear_c   = 1'b1;
        end
      end
      START: begin
        if (tick) begin
          state_n   = DATA;
          bit_idx_n = 3'd0;
          tx_n      = shifter[0];
          clear_c   = 1'b1;
        end
      end
      DATA: begin
        if (tick) begin
          clear_c   = 1'b1;
          bit_idx_n = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
            state_n = STOP;
            tx_n    = 1'b1;
          end else begin
            shifter_n = {1'b1, shifter[DATA_W-1:1]};
            tx_n      = shifter[1];
          end
        end
      end
      STOP: begin
        if (tick) begin
          clear_c = 1'b1;
          if (hold_valid) begin
            shifter_n    = hold_data;
            hold_valid_n = 1'b0;
            state_n      = START;
            tx_n         = 1'b0;
          end else if (bus.i_transmit) begin
            shifter_n = bus.i_data;
            state_n   = START;
            tx_n      = 1'b0;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // A strobe not consumed by the shifter goes to holding, or is dropped if holding stays full
    if (bus.i_transmit && (state != IDLE) && !(stop_end_c && !hold_valid)) begin
      if (!hold_valid || stop_end_c) begin
        hold_data_n  = bus.i_data;
        hold_valid_n = 1'b1;
      end else begin
        overrun_n = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state         <= IDLE;
      shifter       <= '0;
      hold_data     <= '0;
      hold_valid    <= 1'b0;
      bit_idx       <= 3'd0;
      bus.o_tx      <= 1'b1;
      bus.o_busy    <= 1'b0;
      bus.o_ready   <= 1'b1;
      bus.o_done    <= 1'b0;
      bus.o_overrun <= 1'b0;
    end else begin
      state         <= state_n;
      shifter       <= shifter_n;
      hold_data     <= hold_data_n;
      hold_valid    <= hold_valid_n;
      bit_idx       <= bit_idx_n;
      bus.o_tx      <= tx_n;
      bus.o_busy    <= (state_n != IDLE);
      bus.o_ready   <= !hold_valid_n;
      bus.o_done    <= (state_n == STOP) && pre_tick_c;
      bus.o_overrun <= overrun_n;
    end
  end
endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered at CLK_FREQ=16, BAUD=1 (16 clocks per bit).
module tb_uart_tx_buffered;
  import uart_pkg::*;

  localparam int CPB = 16;
  localparam int FRAME = 10 * CPB;

  logic i_clk = 1'b0;
  logic i_rst;
  always #5 i_clk = ~i_clk;

  uart_tx_buffered_if bus ();

  uart_tx_buffered #(.CLK_FREQ(16), .BAUD(1)) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .bus  (bus)
  );

  int total;
  int bad;

  // Strobe table (edge numbers) and expected frame table (first start-bit cycle)
  int         stb_cyc [4];
  logic [7:0] stb_byte[4];
  int         nstb;
  int         fr_start[4];
  logic [7:0] fr_byte [4];
  int         nfr;

  function automatic logic exp_tx(input int c);
    logic [7:0] b;
    for (int i = 0; i < nfr; i++) begin
      int off;
      off = c - fr_start[i];
      if (off >= 0 && off < FRAME) begin
        int j;
        j = off / CPB;
        b = fr_byte[i];
        if (j == 0) return 1'b0;
        if (j == 9) return 1'b1;
        return b[j-1];
      end
    end
    return 1'b1;
  endfunction

  function automatic logic exp_busy(input int c);
    for (int i = 0; i < nfr; i++)
      if (c >= fr_start[i] && c < fr_start[i] + FRAME) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic exp_done(input int c);
    for (int i = 0; i < nfr; i++)
      if (c == fr_start[i] + FRAME - 1) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drive_edge(input int e);
    bus.i_transmit = 1'b0;
    bus.i_data     = 8'h00;
    for (int k = 0; k < nstb; k++)
      if (stb_cyc[k] == e) begin
        bus.i_transmit = 1'b1;
        bus.i_data     = stb_byte[k];
      end
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    bus.i_transmit = 1'b0;
    bus.i_data = 8'h00;
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    #1;
    total++; if (bus.o_tx !== 1'b1)      begin bad++; $display("FAIL reset_tx got=%b exp=1", bus.o_tx); end
    total++; if (bus.o_busy !== 1'b0)    begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.o_busy); end
    total++; if (bus.o_ready !== 1'b1)   begin bad++; $display("FAIL reset_ready got=%b exp=1", bus.o_ready); end
    total++; if (bus.o_done !== 1'b0)    begin bad++; $display("FAIL reset_done got=%b exp=0", bus.o_done); end
    total++; if (bus.o_overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b exp=0", bus.o_overrun); end
  endtask

  task automatic test_single();
    do_reset();
    nstb = 1; stb_cyc[0] = 0; stb_byte[0] = ASCII_SPACE;
    nfr  = 1; fr_start[0] = 1; fr_byte[0] = 8'h20;
    for (int e = 0; e < 200; e++) begin
      int c;
      c = e + 1;
      drive_edge(e);
      @(negedge i_clk);
      total++; if (bus.o_tx !== exp_tx(c))     begin bad++; $display("FAIL single_tx cyc=%0d got=%b exp=%b", c, bus.o_tx, exp_tx(c)); end
      total++; if (bus.o_busy !== exp_busy(c)) begin bad++; $display("FAIL single_busy cyc=%0d got=%b exp=%b", c, bus.o_busy, exp_busy(c)); end
      total++; if (bus.o_done !== exp_done(c)) begin bad++; $display("FAIL single_done cyc=%0d got=%b exp=%b", c, bus.o_done, exp_done(c)); end
      total++; if (bus.o_ready !== 1'b1)       begin bad++; $display("FAIL single_ready cyc=%0d got=%b exp=1", c, bus.o_ready); end
      total++; if (bus.o_overrun !== 1'b0)     begin bad++; $display("FAIL single_overrun cyc=%0d got=%b exp=0", c, bus.o_overrun); end
    end
  endtask

  task automatic test_queued();
    do_reset();
    nstb = 2; stb_cyc[0] = 0; stb_byte[0] = 8'h41; stb_cyc[1] = 5; stb_byte[1] = 8'h42;
    nfr  = 2; fr_start[0] = 1; fr_byte[0] = 8'h41; fr_start[1] = 161; fr_byte[1] = 8'h42;
    for (int e = 0; e < 340; e++) begin
      int c;
      logic er;
      c = e + 1;
      er = !(c >= 6 && c <= 160);
      drive_edge(e);
      @(negedge i_clk);
      total++; if (bus.o_tx !== exp_tx(c))     begin bad++; $display("FAIL queued_tx cyc=%0d got=%b exp=%b", c, bus.o_tx, exp_tx(c)); end
      total++; if (bus.o_busy !== exp_busy(c)) begin bad++; $display("FAIL queued_busy cyc=%0d got=%b exp=%b", c, bus.o_busy, exp_busy(c)); end
      total++; if (bus.o_done !== exp_done(c)) begin bad++; $display("FAIL queued_done cyc=%0d got=%b exp=%b", c, bus.o_done, exp_done(c)); end
      total++; if (bus.o_ready !== er)         begin bad++; $display("FAIL queued_ready cyc=%0d got=%b exp=%b", c, bus.o_ready, er); end
      total++; if (bus.o_overrun !== 1'b0)     begin bad++; $display("FAIL queued_overrun cyc=%0d got=%b exp=0", c, bus.o_overrun); end
    end
  endtask

  task automatic test_overrun();
    do_reset();
    nstb = 3; stb_cyc[0] = 0; stb_byte[0] = 8'h41; stb_cyc[1] = 5; stb_byte[1] = 8'h42;
    stb_cyc[2] = 9; stb_byte[2] = 8'h43;
    nfr  = 2; fr_start[0] = 1; fr_byte[0] = 8'h41; fr_start[1] = 161; fr_byte[1] = 8'h42;
    for (int e = 0; e < 340; e++) begin
      int c;
      logic er, eo;
      c = e + 1;
      er = !(c >= 6 && c <= 160);
      eo = (c == 10);
      drive_edge(e);
      @(negedge i_clk);
      total++; if (bus.o_tx !== exp_tx(c))     begin bad++; $display("FAIL overrun_tx cyc=%0d got=%b exp=%b", c, bus.o_tx, exp_tx(c)); end
      total++; if (bus.o_busy !== exp_busy(c)) begin bad++; $display("FAIL overrun_busy cyc=%0d got=%b exp=%b", c, bus.o_busy, exp_busy(c)); end
      total++; if (bus.o_done !== exp_done(c)) begin bad++; $display("FAIL overrun_done cyc=%0d got=%b exp=%b", c, bus.o_done, exp_done(c)); end
      total++; if (bus.o_ready !== er)         begin bad++; $display("FAIL overrun_ready cyc=%0d got=%b exp=%b", c, bus.o_ready, er); end
      total++; if (bus.o_overrun !== eo)       begin bad++; $display("FAIL overrun_pulse cyc=%0d got=%b exp=%b", c, bus.o_overrun, eo); end
    end
  endtask

  task automatic test_stop_collision();
    do_reset();
    nstb = 3; stb_cyc[0] = 0; stb_byte[0] = 8'h41; stb_cyc[1] = 5; stb_byte[1] = 8'h42;
    stb_cyc[2] = 160; stb_byte[2] = 8'h55;
    nfr  = 3; fr_start[0] = 1; fr_byte[0] = 8'h41; fr_start[1] = 161; fr_byte[1] = 8'h42;
    fr_start[2] = 321; fr_byte[2] = 8'h55;
    for (int e = 0; e < 500; e++) begin
      int c;
      logic er;
      c = e + 1;
      er = !(c >= 6 && c <= 320);
      drive_edge(e);
      @(negedge i_clk);
      total++; if (bus.o_tx !== exp_tx(c))     begin bad++; $display("FAIL collide_tx cyc=%0d got=%b exp=%b", c, bus.o_tx, exp_tx(c)); end
      total++; if (bus.o_busy !== exp_busy(c)) begin bad++; $display("FAIL collide_busy cyc=%0d got=%b exp=%b", c, bus.o_busy, exp_busy(c)); end
      total++; if (bus.o_done !== exp_done(c)) begin bad++; $display("FAIL collide_done cyc=%0d got=%b exp=%b", c, bus.o_done, exp_done(c)); end
      total++; if (bus.o_ready !== er)         begin bad++; $display("FAIL collide_ready cyc=%0d got=%b exp=%b", c, bus.o_ready, er); end
      total++; if (bus.o_overrun !== 1'b0)     begin bad++; $display("FAIL collide_overrun cyc=%0d got=%b exp=0", c, bus.o_overrun); end
    end
  endtask

  task automatic test_stop_direct();
    do_reset();
    nstb = 2; stb_cyc[0] = 0; stb_byte[0] = 8'h41; stb_cyc[1] = 160; stb_byte[1] = 8'h5A;
    nfr  = 2; fr_start[0] = 1; fr_byte[0] = 8'h41; fr_start[1] = 161; fr_byte[1] = 8'h5A;
    for (int e = 0; e < 340; e++) begin
      int c;
      c = e + 1;
      drive_edge(e);
      @(negedge i_clk);
      total++; if (bus.o_tx !== exp_tx(c))     begin bad++; $display("FAIL direct_tx cyc=%0d got=%b exp=%b", c, bus.o_tx, exp_tx(c)); end
      total++; if (bus.o_busy !== exp_busy(c)) begin bad++; $display("FAIL direct_busy cyc=%0d got=%b exp=%b", c, bus.o_busy, exp_busy(c)); end
      total++; if (bus.o_done !== exp_done(c)) begin bad++; $display("FAIL direct_done cyc=%0d got=%b exp=%b", c, bus.o_done, exp_done(c)); end
      total++; if (bus.o_ready !== 1'b1)       begin bad++; $display("FAIL direct_ready cyc=%0d got=%b exp=1", c, bus.o_ready); end
      total++; if (bus.o_overrun !== 1'b0)     begin bad++; $display("FAIL direct_overrun cyc=%0d got=%b exp=0", c, bus.o_overrun); end
    end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    nstb = 2; stb_cyc[0] = 0; stb_byte[0] = 8'h41; stb_cyc[1] = 5; stb_byte[1] = 8'h42;
    nfr  = 1; fr_start[0] = 1; fr_byte[0] = 8'h41;
    for (int e = 0; e < 50; e++) begin
      int c;
      c = e + 1;
      drive_edge(e);
      @(negedge i_clk);
      total++; if (bus.o_tx !== exp_tx(c)) begin bad++; $display("FAIL midrst_pre_tx cyc=%0d got=%b exp=%b", c, bus.o_tx, exp_tx(c)); end
    end
    // Mid-cycle reset: no clock edge between assertion and the checks
    i_rst = 1'b1;
    #1;
    total++; if (bus.o_tx !== 1'b1)    begin bad++; $display("FAIL midrst_tx got=%b exp=1", bus.o_tx); end
    total++; if (bus.o_busy !== 1'b0)  begin bad++; $display("FAIL midrst_busy got=%b exp=0", bus.o_busy); end
    total++; if (bus.o_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready got=%b exp=1", bus.o_ready); end
    @(negedge i_clk);
    i_rst = 1'b0;
    nstb = 1; stb_cyc[0] = 0; stb_byte[0] = 8'h55;
    nfr  = 1; fr_start[0] = 1; fr_byte[0] = 8'h55;
    for (int e = 0; e < 200; e++) begin
      int c;
      c = e + 1;
      drive_edge(e);
      @(negedge i_clk);
      total++; if (bus.o_tx !== exp_tx(c))     begin bad++; $display("FAIL midrst_tx cyc=%0d got=%b exp=%b", c, bus.o_tx, exp_tx(c)); end
      total++; if (bus.o_busy !== exp_busy(c)) begin bad++; $display("FAIL midrst_busy cyc=%0d got=%b exp=%b", c, bus.o_busy, exp_busy(c)); end
      total++; if (bus.o_done !== exp_done(c)) begin bad++; $display("FAIL midrst_done cyc=%0d got=%b exp=%b", c, bus.o_done, exp_done(c)); end
      total++; if (bus.o_ready !== 1'b1)       begin bad++; $display("FAIL midrst_ready cyc=%0d got=%b exp=1", c, bus.o_ready); end
    end
  endtask

  task automatic test_idle();
    do_reset();
    nstb = 0;
    nfr  = 0;
    for (int e = 0; e < 1000; e++) begin
      drive_edge(e);
      @(negedge i_clk);
      total++; if (bus.o_tx !== 1'b1)      begin bad++; $display("FAIL idle_tx cyc=%0d got=%b exp=1", e + 1, bus.o_tx); end
      total++; if (bus.o_busy !== 1'b0)    begin bad++; $display("FAIL idle_busy cyc=%0d got=%b exp=0", e + 1, bus.o_busy); end
      total++; if (bus.o_done !== 1'b0)    begin bad++; $display("FAIL idle_done cyc=%0d got=%b exp=0", e + 1, bus.o_done); end
      total++; if (bus.o_overrun !== 1'b0) begin bad++; $display("FAIL idle_overrun cyc=%0d got=%b exp=0", e + 1, bus.o_overrun); end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    nstb  = 0;
    nfr   = 0;
    i_rst = 1'b1;
    bus.i_transmit = 1'b0;
    bus.i_data     = 8'h00;
    test_reset();
    test_single();
    test_queued();
    test_overrun();
    test_stop_collision();
    test_stop_direct();
    test_reset_mid_frame();
    test_idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
